// File: rtl/led_panel_bcm.sv
// led_panel_bcm: HUB-style LED panel scan driver with binary-coded modulation.
// Shifts an internal DEPTH-bit test pattern column-serially into the panel,
// one bit-plane at a time, and steps the panel's row counter via aclk/arst.
// All outputs are registered, so each output cycle shows the phase decoded
// from the state held one clock earlier.
// Optional feature macro: LED_PANEL_DEADTIME_EN (stretches ADVANCE to 6 cycles).
module led_panel_bcm #(
    parameter int COLS      = 32,
    parameter int ROW_BITS  = 3,
    parameter int DEPTH     = 2,
    parameter int DISP_BASE = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ROW_BITS-1:0] rowmax_in,
    input  logic [1:0]          mode_in,
    output logic                red_out,
    output logic                green_out,
    output logic                blue_out,
    output logic                sclk_out,
    output logic                latch_out,
    output logic                blank_out,
    output logic                aclk_out,
    output logic                arst_out,
    output logic                frame_out
);

    localparam int COL_W    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int PLANE_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DISP_MAX = DISP_BASE << (DEPTH - 1);
    localparam int CNT_W    = $clog2(DISP_MAX + 1);
    localparam int ADV_W    = 3;
`ifdef LED_PANEL_DEADTIME_EN
    // Strobe in the first cycle, then five more blanked cycles against ghosting.
    localparam int ADV_LEN  = 6;
`else
    localparam int ADV_LEN  = 2;
`endif

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(DEPTH - 1);
    localparam logic [ADV_W-1:0]   ADV_LAST   = ADV_W'(ADV_LEN - 1);

    localparam logic [2:0] ST_INIT    = 3'd0;
    localparam logic [2:0] ST_SHIFT   = 3'd1;
    localparam logic [2:0] ST_LATCH   = 3'd2;
    localparam logic [2:0] ST_DISPLAY = 3'd3;
    localparam logic [2:0] ST_ADVANCE = 3'd4;

    // Sequencing state
    logic [2:0]          state_r;
    logic [COL_W-1:0]    col_r;
    logic                half_r;      // 0 = data setup cycle, 1 = sclk high cycle
    logic [PLANE_W-1:0]  plane_r;
    logic [CNT_W-1:0]    disp_cnt_r;
    logic [ADV_W-1:0]    adv_cnt_r;
    logic [ROW_BITS-1:0] row_r;
    logic [7:0]          frame_r;
    logic [1:0]          mode_r;

    // Registered outputs
    logic red_r, green_r, blue_r, sclk_r, latch_r, blank_r, aclk_r, arst_r, frame_pulse_r;

    // Decoded next values
    logic red_s, green_s, blue_s, sclk_s, latch_s, blank_s, aclk_s, arst_s, frame_pulse_s;
    logic pat_r_s, pat_g_s, pat_b_s;
    logic col_bit_s, row_bit_s, frame_bit_s, checker_s;
    logic wrap_s;
    logic [CNT_W-1:0] disp_last_s;

    assign red_out   = red_r;
    assign green_out = green_r;
    assign blue_out  = blue_r;
    assign sclk_out  = sclk_r;
    assign latch_out = latch_r;
    assign blank_out = blank_r;
    assign aclk_out  = aclk_r;
    assign arst_out  = arst_r;
    assign frame_out = frame_pulse_r;

    // Last display count of the current plane and end-of-frame decision
    always_comb begin
        disp_last_s = CNT_W'((DISP_BASE << plane_r) - 1);
        wrap_s      = (row_r >= rowmax_in);
    end

    // Test-pattern bit of the current pixel in the current bit-plane
    always_comb begin
        // Bit 'plane' of x mod 2^DEPTH is simply bit 'plane' of x (zero above its width).
        col_bit_s   = |((col_r >> plane_r) & COL_W'(1'b1));
        row_bit_s   = |((row_r >> plane_r) & ROW_BITS'(1'b1));
        frame_bit_s = |((frame_r >> plane_r) & 8'd1);
        checker_s   = col_r[0] ^ row_r[0];
        pat_r_s     = 1'b0;
        pat_g_s     = 1'b0;
        pat_b_s     = 1'b0;
        case (mode_r)
            2'd0: begin
                pat_r_s = 1'b1;
                pat_g_s = 1'b1;
                pat_b_s = 1'b1;
            end
            2'd1: begin
                pat_r_s = col_bit_s;
                pat_g_s = row_bit_s;
                pat_b_s = frame_bit_s;
            end
            2'd2: begin
                pat_r_s = checker_s;
                pat_g_s = checker_s;
                pat_b_s = checker_s;
            end
            default: begin
                pat_r_s = 1'b0;
                pat_g_s = 1'b0;
                pat_b_s = 1'b0;
            end
        endcase
    end

    // Output decode for the phase held in the state registers
    always_comb begin
        red_s         = red_r;
        green_s       = green_r;
        blue_s        = blue_r;
        sclk_s        = 1'b0;
        latch_s       = 1'b0;
        blank_s       = 1'b1;
        aclk_s        = 1'b0;
        arst_s        = 1'b0;
        frame_pulse_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                arst_s = 1'b1;
            end
            ST_SHIFT: begin
                // Same column in both halves, so data is stable around the sclk rise.
                sclk_s  = half_r;
                red_s   = pat_r_s;
                green_s = pat_g_s;
                blue_s  = pat_b_s;
            end
            ST_LATCH: begin
                latch_s = 1'b1;
            end
            ST_DISPLAY: begin
                blank_s = 1'b0;
            end
            ST_ADVANCE: begin
                if (adv_cnt_r == ADV_W'(0)) begin
                    if (wrap_s) begin
                        arst_s        = 1'b1;
                        frame_pulse_s = 1'b1;
                    end else begin
                        aclk_s = 1'b1;
                    end
                end else begin
                    aclk_s = 1'b0;
                end
            end
            default: begin
                blank_s = 1'b1;
            end
        endcase
    end

    // Scan sequencer and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_INIT;
            col_r         <= '0;
            half_r        <= 1'b0;
            plane_r       <= '0;
            disp_cnt_r    <= '0;
            adv_cnt_r     <= '0;
            row_r         <= '0;
            frame_r       <= 8'd0;
            mode_r        <= 2'd0;
            red_r         <= 1'b0;
            green_r       <= 1'b0;
            blue_r        <= 1'b0;
            sclk_r        <= 1'b0;
            latch_r       <= 1'b0;
            blank_r       <= 1'b1;
            aclk_r        <= 1'b0;
            arst_r        <= 1'b0;
            frame_pulse_r <= 1'b0;
        end else begin
            red_r         <= red_s;
            green_r       <= green_s;
            blue_r        <= blue_s;
            sclk_r        <= sclk_s;
            latch_r       <= latch_s;
            blank_r       <= blank_s;
            aclk_r        <= aclk_s;
            arst_r        <= arst_s;
            frame_pulse_r <= frame_pulse_s;
            case (state_r)
                ST_INIT: begin
                    mode_r  <= mode_in;
                    col_r   <= '0;
                    half_r  <= 1'b0;
                    plane_r <= '0;
                    state_r <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!half_r) begin
                        half_r <= 1'b1;
                    end else begin
                        half_r <= 1'b0;
                        if (col_r == COL_LAST) begin
                            col_r   <= '0;
                            state_r <= ST_LATCH;
                        end else begin
                            col_r <= col_r + COL_W'(1'b1);
                        end
                    end
                end
                ST_LATCH: begin
                    disp_cnt_r <= '0;
                    state_r    <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    if (disp_cnt_r == disp_last_s) begin
                        disp_cnt_r <= '0;
                        if (plane_r == PLANE_LAST) begin
                            plane_r   <= '0;
                            adv_cnt_r <= '0;
                            state_r   <= ST_ADVANCE;
                        end else begin
                            plane_r <= plane_r + PLANE_W'(1'b1);
                            state_r <= ST_SHIFT;
                        end
                    end else begin
                        disp_cnt_r <= disp_cnt_r + CNT_W'(1'b1);
                    end
                end
                ST_ADVANCE: begin
                    // Row bookkeeping happens with the strobe so the new row is valid for SHIFT.
                    if (adv_cnt_r == ADV_W'(0)) begin
                        if (wrap_s) begin
                            row_r   <= '0;
                            frame_r <= frame_r + 8'd1;
                            mode_r  <= mode_in;
                        end else begin
                            row_r <= row_r + ROW_BITS'(1'b1);
                        end
                    end else begin
                        row_r <= row_r;
                    end
                    if (adv_cnt_r == ADV_LAST) begin
                        adv_cnt_r <= '0;
                        state_r   <= ST_SHIFT;
                    end else begin
                        adv_cnt_r <= adv_cnt_r + ADV_W'(1'b1);
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

endmodule
